// File: rtl/hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller, forwarding and decode.
package hazard_controller_pkg;

  localparam int REG_W   = 5;
  localparam int TIMER_W = 8;

  // Canonical bubble instruction (addi x0, x0, 0) and major opcodes used by decode/forwarding.
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [6:0]  OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0]  OPC_STORE  = 7'b010_0011;
  localparam logic [6:0]  OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0]  OPC_JAL    = 7'b110_1111;
  localparam logic [6:0]  OPC_JALR   = 7'b110_0111;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } hz_state_e;

  // A load in ID/EX feeds a register the IF/ID instruction really reads; x0 never hazards.
  function automatic logic isLoadUse(
    input logic             memread,
    input logic [REG_W-1:0] rd,
    input logic [REG_W-1:0] rs1,
    input logic [REG_W-1:0] rs2,
    input logic             useRs1,
    input logic             useRs2
  );
    return memread && (rd != '0) &&
           (((rd == rs1) && useRs1) || ((rd == rs2) && useRs2));
  endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline-side signal bundle of the hazard controller.
interface hazard_controller_if #(
  parameter int CNT_W = 16
);
  logic             in_idex_memread;
  logic [4:0]       in_idex_rd;
  logic [4:0]       in_ifid_rs1;
  logic [4:0]       in_ifid_rs2;
  logic             in_ifid_use_rs1;
  logic             in_ifid_use_rs2;
  logic             in_ex_branch_taken;
  logic             in_mem_req;
  logic             in_mem_ready;

  logic             out_pc_write;
  logic             out_ifid_write;
  logic             out_idex_write;
  logic             out_exmem_write;
  logic             out_ifid_flush;
  logic             out_idex_flush;
  logic             out_memwb_bubble;
  logic             out_mem_error;
  logic [CNT_W-1:0] out_stall_cnt;
  logic [CNT_W-1:0] out_flush_cnt;

  // The pipeline drives hazard sources and consumes the stage controls.
  modport master (
    output in_idex_memread, in_idex_rd, in_ifid_rs1, in_ifid_rs2,
           in_ifid_use_rs1, in_ifid_use_rs2, in_ex_branch_taken,
           in_mem_req, in_mem_ready,
    input  out_pc_write, out_ifid_write, out_idex_write, out_exmem_write,
           out_ifid_flush, out_idex_flush, out_memwb_bubble, out_mem_error,
           out_stall_cnt, out_flush_cnt
  );

  // The hazard controller itself.
  modport slave (
    input  in_idex_memread, in_idex_rd, in_ifid_rs1, in_ifid_rs2,
           in_ifid_use_rs1, in_ifid_use_rs2, in_ex_branch_taken,
           in_mem_req, in_mem_ready,
    output out_pc_write, out_ifid_write, out_idex_write, out_exmem_write,
           out_ifid_flush, out_idex_flush, out_memwb_bubble, out_mem_error,
           out_stall_cnt, out_flush_cnt
  );
endinterface

// File: rtl/hazard_controller_sat_counter.sv
// Saturating event counter: counts up to all-ones and then sticks there.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  // Count events, holding at all-ones instead of wrapping so overflow stays visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: memory-wait freeze, branch flush and load-use stall.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  hazard_controller_if.slave hz
);

  localparam logic [TIMER_W-1:0] TIMEOUT_L = TIMER_W'(TIMEOUT);

  hz_state_e          state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;

  logic memHold;
  logic loadUse;
  logic stallEvt;
  logic flushEvt;
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;

  assign memHold = hz.in_mem_req & ~hz.in_mem_ready;
  assign loadUse = isLoadUse(hz.in_idex_memread, hz.in_idex_rd, hz.in_ifid_rs1,
                             hz.in_ifid_rs2, hz.in_ifid_use_rs1, hz.in_ifid_use_rs2);

  // State and wait timer registers; reset drops any wait or error straight back to RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Next state and stage controls; a memory hold outranks branch flush, which outranks load-use.
  always_comb begin
    logic freeze;
    logic runRules;
    state_d             = state_q;
    timer_d             = timer_q;
    freeze              = 1'b0;
    runRules            = 1'b0;
    stallEvt            = 1'b0;
    flushEvt            = 1'b0;
    hz.out_pc_write     = 1'b1;
    hz.out_ifid_write   = 1'b1;
    hz.out_idex_write   = 1'b1;
    hz.out_exmem_write  = 1'b1;
    hz.out_ifid_flush   = 1'b0;
    hz.out_idex_flush   = 1'b0;
    hz.out_memwb_bubble = 1'b0;
    hz.out_mem_error    = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (memHold) begin
          freeze  = 1'b1;
          state_d = ST_MEM_WAIT;
          timer_d = '0;
        end else begin
          runRules = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (memHold) begin
          freeze = 1'b1;
          if (timer_q >= TIMEOUT_L) begin
            hz.out_mem_error = 1'b1;
            state_d          = ST_ERROR;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end else begin
          runRules = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_ERROR: begin
        freeze = 1'b1;
      end
      default: begin
        freeze  = 1'b1;
        state_d = ST_RUN;
      end
    endcase

    if (freeze) begin
      hz.out_pc_write     = 1'b0;
      hz.out_ifid_write   = 1'b0;
      hz.out_idex_write   = 1'b0;
      hz.out_exmem_write  = 1'b0;
      hz.out_memwb_bubble = 1'b1;
    end else if (runRules && hz.in_ex_branch_taken) begin
      hz.out_ifid_flush = 1'b1;
      hz.out_idex_flush = 1'b1;
      flushEvt          = 1'b1;
    end else if (runRules && loadUse) begin
      hz.out_pc_write   = 1'b0;
      hz.out_ifid_write = 1'b0;
      hz.out_idex_flush = 1'b1;
      stallEvt          = 1'b1;
    end
  end

  // No software clear exists in this pipeline, so only reset zeroes the counters.
  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear_i (1'b0),
    .inc_i   (stallEvt),
    .count_o (stallCnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear_i (1'b0),
    .inc_i   (flushEvt),
    .count_o (flushCnt)
  );

  assign hz.out_stall_cnt = stallCnt;
  assign hz.out_flush_cnt = flushCnt;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench: dutA (TIMEOUT=4, 16-bit counters) and dutB (2-bit counters) share stimulus.
module tb_hazard_controller;

  // Output pattern {pc_w, ifid_w, idex_w, exmem_w, ifid_fl, idex_fl, bubble, err}
  localparam logic [7:0] DEF_O   = 8'b1111_0000;
  localparam logic [7:0] STALL_O = 8'b0011_0100;
  localparam logic [7:0] FLUSH_O = 8'b1111_1100;
  localparam logic [7:0] HOLD_O  = 8'b0000_0010;
  localparam logic [7:0] HERR_O  = 8'b0000_0011;

  typedef struct {
    logic       memread;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic       br;
    logic       mreq;
    logic       mrdy;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0] outs;
    int         stallA;
    int         flushA;
    int         stallB;
    bit         chkB;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nChecks = 0;
  int   nPass   = 0;
  int   mStallA = 0;
  int   mFlushA = 0;
  int   mStallB = 0;
  exp_t sbq[$];
  vec_t tbl[13];
  string tblName[13];

  hazard_controller_if #(.CNT_W(16)) busA ();
  hazard_controller_if #(.CNT_W(2))  busB ();

  hazard_controller #(.TIMEOUT(4), .CNT_W(16)) dutA (.clk(clk), .rst(rst), .hz(busA));
  hazard_controller #(.TIMEOUT(16), .CNT_W(2)) dutB (.clk(clk), .rst(rst), .hz(busB));

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic u1, input logic u2,
                              input logic br, input logic mq, input logic my,
                              input logic [7:0] e);
    vec_t v;
    v.memread = mr; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.use1 = u1; v.use2 = u2;
    v.br = br; v.mreq = mq; v.mrdy = my; v.exp = e;
    return v;
  endfunction

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] req);
    nChecks++;
    if (act !== req) $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    else nPass++;
  endtask

  task automatic driveInputs(input vec_t v);
    busA.in_idex_memread = v.memread;  busB.in_idex_memread = v.memread;
    busA.in_idex_rd = v.rd;            busB.in_idex_rd = v.rd;
    busA.in_ifid_rs1 = v.rs1;          busB.in_ifid_rs1 = v.rs1;
    busA.in_ifid_rs2 = v.rs2;          busB.in_ifid_rs2 = v.rs2;
    busA.in_ifid_use_rs1 = v.use1;     busB.in_ifid_use_rs1 = v.use1;
    busA.in_ifid_use_rs2 = v.use2;     busB.in_ifid_use_rs2 = v.use2;
    busA.in_ex_branch_taken = v.br;    busB.in_ex_branch_taken = v.br;
    busA.in_mem_req = v.mreq;          busB.in_mem_req = v.mreq;
    busA.in_mem_ready = v.mrdy;        busB.in_mem_ready = v.mrdy;
  endtask

  // Drive one cycle of stimulus just after the edge and queue what the DUT must show this cycle.
  task automatic applyStimulus(input vec_t v, input string name, input bit chkB);
    exp_t e;
    @(posedge clk);
    #1;
    driveInputs(v);
    e.outs = v.exp; e.stallA = mStallA; e.flushA = mFlushA; e.stallB = mStallB;
    e.chkB = chkB; e.name = name;
    sbq.push_back(e);
    if (v.exp == STALL_O) begin
      if (mStallA < 65535) mStallA++;
      if (mStallB < 3) mStallB++;
    end
    if (v.exp == FLUSH_O && mFlushA < 65535) mFlushA++;
  endtask

  // Compare the oldest queued expectation against the DUT at the falling edge.
  task automatic checkOutput();
    exp_t e;
    @(negedge clk);
    if (sbq.size() == 0) begin
      checkEq("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sbq.pop_front();
    checkEq({e.name, "_outs"},
            {24'd0, busA.out_pc_write, busA.out_ifid_write, busA.out_idex_write,
             busA.out_exmem_write, busA.out_ifid_flush, busA.out_idex_flush,
             busA.out_memwb_bubble, busA.out_mem_error}, {24'd0, e.outs});
    checkEq({e.name, "_stall_cnt"}, {16'd0, busA.out_stall_cnt}, e.stallA);
    checkEq({e.name, "_flush_cnt"}, {16'd0, busA.out_flush_cnt}, e.flushA);
    if (e.chkB) checkEq({e.name, "_stall_cnt_w2"}, {30'd0, busB.out_stall_cnt}, e.stallB);
  endtask

  task automatic step(input vec_t v, input string name, input bit chkB);
    applyStimulus(v, name, chkB);
    checkOutput();
  endtask

  // Assert reset asynchronously mid-cycle, check defaults and zeroed counters, then release.
  task automatic doReset(input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst = 1'b1;
    driveInputs(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF_O));
    mStallA = 0; mFlushA = 0; mStallB = 0;
    e.outs = DEF_O; e.stallA = 0; e.flushA = 0; e.stallB = 0; e.chkB = 1'b1; e.name = name;
    sbq.push_back(e);
    checkOutput();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] simulation did not finish in time");
  end

  initial begin
    driveInputs(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF_O));

    tbl[0]  = mk(0,  0,  0,  0, 0, 0, 0, 0, 0, DEF_O);   tblName[0]  = "idle";
    tbl[1]  = mk(1,  5,  5,  0, 1, 0, 0, 0, 0, STALL_O); tblName[1]  = "lu_rs1";
    tbl[2]  = mk(1,  0,  0,  0, 1, 0, 0, 0, 0, DEF_O);   tblName[2]  = "lu_rd0";
    tbl[3]  = mk(1,  5,  5,  0, 0, 0, 0, 0, 0, DEF_O);   tblName[3]  = "lu_nouse1";
    tbl[4]  = mk(0,  5,  5,  0, 1, 0, 0, 0, 0, DEF_O);   tblName[4]  = "no_load";
    tbl[5]  = mk(1,  7,  3,  7, 0, 1, 0, 0, 0, STALL_O); tblName[5]  = "lu_rs2";
    tbl[6]  = mk(1,  7,  3,  7, 1, 0, 0, 0, 0, DEF_O);   tblName[6]  = "lu_nouse2";
    tbl[7]  = mk(0,  0,  0,  0, 0, 0, 1, 0, 0, FLUSH_O); tblName[7]  = "branch";
    tbl[8]  = mk(1,  5,  5,  0, 1, 0, 1, 0, 0, FLUSH_O); tblName[8]  = "branch_over_lu";
    tbl[9]  = mk(1,  9,  9,  9, 1, 1, 0, 1, 1, STALL_O); tblName[9]  = "lu_mem_ready";
    tbl[10] = mk(1,  9, 10, 11, 1, 1, 0, 0, 0, DEF_O);   tblName[10] = "lu_mismatch";
    tbl[11] = mk(1, 31, 31, 31, 1, 1, 0, 0, 0, STALL_O); tblName[11] = "lu_x31";
    tbl[12] = mk(0,  0,  0,  0, 0, 0, 0, 0, 0, DEF_O);   tblName[12] = "idle_end";

    doReset("reset_init");

    for (int i = 0; i < 13; i++) step(tbl[i], tblName[i], 1'b1);

    // Memory wait: three frozen cycles (hold beats branch and load-use), then the return cycle flushes.
    step(mk(1, 5, 5, 0, 1, 0, 0, 1, 0, HOLD_O),  "mw_hold1", 1'b1);
    step(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, HOLD_O),  "mw_hold2", 1'b1);
    step(mk(1, 5, 5, 0, 1, 0, 1, 1, 0, HOLD_O),  "mw_hold3", 1'b1);
    step(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, FLUSH_O), "mw_ready_branch", 1'b1);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF_O),   "mw_after", 1'b1);
    // Dropping the request also ends the wait; the load-use rule applies in that cycle.
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD_O),  "mw2_hold", 1'b1);
    step(mk(1, 4, 0, 4, 0, 1, 0, 0, 0, STALL_O), "mw2_req_drop_lu", 1'b1);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF_O),   "mw2_after", 1'b1);

    // Narrow counter saturates at 3 over five consecutive stalls and stays there.
    doReset("reset_sat");
    for (int i = 0; i < 5; i++) step(mk(1, 6, 6, 0, 1, 0, 0, 0, 0, STALL_O), $sformatf("sat_stall%0d", i), 1'b1);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF_O), "sat_idle0", 1'b1);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF_O), "sat_idle1", 1'b1);

    // Timeout on dutA: RUN hold, four MEM_WAIT cycles, then the error pulse cycle.
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD_O), "to_run_hold", 1'b0);
    for (int i = 0; i < 4; i++) step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD_O), $sformatf("to_wait%0d", i), 1'b0);
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, HERR_O), "to_error_pulse", 1'b0);
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD_O), "err_hold", 1'b0);
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, HOLD_O), "err_branch", 1'b0);
    step(mk(1, 5, 5, 0, 1, 0, 0, 1, 1, HOLD_O), "err_ready_lu", 1'b0);

    doReset("reset_from_error");
    step(mk(1, 5, 5, 0, 1, 0, 0, 0, 0, STALL_O), "post_reset_lu", 1'b1);
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, FLUSH_O), "post_reset_br", 1'b1);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF_O),   "post_reset_idle", 1'b1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: max MEM_WAIT cycles before error, range 1..255.
REQ-002 SHALL have parameter CNT_W, default 16: width of the performance counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_idex_memread  input  1  load instruction in ID/EX.
REQ-006 in_idex_rd  input  5  destination register of the ID/EX instruction.
REQ-007 in_ifid_rs1 / in_ifid_rs2  input  5 each  source registers of the IF/ID instruction.
REQ-008 in_ifid_use_rs1 / in_ifid_use_rs2  input  1 each  IF/ID instruction actually reads rs1/rs2.
REQ-009 in_ex_branch_taken  input  1  branch or jump resolved taken in EX this cycle.
REQ-010 in_mem_req  input  1  EX/MEM instruction accesses data memory.
REQ-011 in_mem_ready  input  1  data memory completes the access this cycle.
REQ-012 out_pc_write, out_ifid_write, out_idex_write, out_exmem_write  output  1 each  register enables, active-high.
REQ-013 out_ifid_flush, out_idex_flush, out_memwb_bubble  output  1 each  insert NOP into that stage.
REQ-014 out_mem_error  output  1  single-cycle pulse on timeout.
REQ-015 out_stall_cnt, out_flush_cnt  output  CNT_W each  saturating event counters.

Function
REQ-016 SHALL implement FSM states RUN, MEM_WAIT and ERROR; outputs are combinational from state and inputs; counters and timer are registered.
REQ-017 Default output state: all write enables 1, all flush and bubble outputs 0, out_mem_error 0.
REQ-018 Memory hold: if in_mem_req=1 and in_mem_ready=0 in RUN or MEM_WAIT, all four write enables SHALL be 0, out_memwb_bubble 1, all flush outputs 0; RUN moves to MEM_WAIT.
REQ-019 MEM_WAIT SHALL return to RUN in the cycle in_mem_ready=1 or in_mem_req=0; in that cycle the branch and load-use rules apply normally.
REQ-020 Timer SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle.
REQ-021 If the timer reaches TIMEOUT with ready still 0, out_mem_error SHALL pulse 1 for one cycle and the FSM SHALL enter ERROR.
REQ-022 ERROR SHALL hold the full freeze of REQ-018 until reset.
REQ-023 Branch flush: in RUN with no memory hold, in_ex_branch_taken=1 SHALL assert out_ifid_flush and out_idex_flush for exactly that cycle; out_pc_write stays 1.
REQ-024 Load-use condition: in_idex_memread=1, in_idex_rd!=0, and (rd==rs1 with use_rs1=1, or rd==rs2 with use_rs2=1).
REQ-025 Load-use stall: when the condition holds, with no memory hold and no branch, SHALL drive out_pc_write=0, out_ifid_write=0 and out_idex_flush=1 for one cycle.
REQ-026 Priority: memory hold > branch flush > load-use; a simultaneous branch SHALL suppress the load-use stall.
REQ-027 out_stall_cnt SHALL increment once per load-use stall cycle; out_flush_cnt once per branch flush cycle; both saturate at all-ones with no wrap.

Reset
REQ-028 rst=1 SHALL immediately force state RUN, timer 0, both counters 0 and out_mem_error 0, including mid-MEM_WAIT and in ERROR.
REQ-029 Outputs during and after reset SHALL follow the REQ-017 defaults unless inputs trigger a hold, flush or stall.

Structure
REQ-030 The shared package/header SHALL hold the FSM state encodings and the NOP/opcode constants shared with forwarding and decode logic.
REQ-031 SHALL instantiate sub-module sat_counter, parameterised by width with inc and clear inputs, twice.

Verification
REQ-032 idex_memread=1, rd=5, ifid rs1=5, use_rs1=1 -> one cycle with pc_write=0, ifid_write=0, idex_flush=1; stall_cnt 0->1.
REQ-033 Same as REQ-032 but rd=0, or use_rs1=0 -> no stall, all defaults.
REQ-034 Load-use condition and branch_taken=1 together -> ifid_flush=1, idex_flush=1, pc_write=1; flush_cnt+1, stall_cnt unchanged.
REQ-035 mem_req=1, ready=0 for 3 cycles then 1 -> 3 frozen cycles with memwb_bubble=1, RUN on the 4th cycle, no error.
REQ-036 TIMEOUT=4, mem_req=1, ready=0 held -> error pulse after 4 MEM_WAIT cycles, freeze persists; rst=1 -> RUN and counters 0.
REQ-037 CNT_W=2, 5 load-use stalls -> stall_cnt reads 3 and stays at 3.
